gray_seq_ctrl: RTL and testbench
================================

GRAY_SEQ_CTRL -- requirements
Module: gray_seq_ctrl

Interface
REQ-001 Parameter N, default 4: Gray code width in bits, minimum 2.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  launch a sequence; sampled only in IDLE.
REQ-005 stop  input  1  abort an active sequence.
REQ-006 mode  input  1  0 = one-shot, 1 = continuous; sampled with start.
REQ-007 term_gray  input  N  terminal code, in Gray, sampled with start.
REQ-008 out_ready  input  1  consumer accepts gray_out this cycle.
REQ-009 gray_out  output  N  current Gray code.
REQ-010 out_valid  output  1  gray_out is valid for transfer.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse on completion of a one-shot sequence.
REQ-013 wrap_cnt  output  8  count of continuous-mode restarts, saturating at 255.

Function
REQ-014 The block SHALL have the states IDLE, RUN and DONE.
REQ-015 In IDLE, start=1 and stop=0 SHALL latch mode and term_gray, load gray_out=0, clear wrap_cnt and enter RUN on the next edge.
REQ-016 In RUN, out_valid SHALL be 1 and gray_out SHALL hold stable until a transfer occurs, where a transfer is out_valid&out_ready.
REQ-017 On a transfer with gray_out!=term_gray, gray_out SHALL advance to the next reflected-binary Gray code, changing exactly one bit.
REQ-018 On a transfer with gray_out==term_gray in one-shot mode, the block SHALL enter DONE and drop out_valid.
REQ-019 On a transfer with gray_out==term_gray in continuous mode, gray_out SHALL reload to 0, wrap_cnt SHALL increment and the block SHALL remain in RUN.
REQ-020 Natural wrap from the Gray code for 2^N-1 (MSB only set) SHALL go to 0 without incrementing wrap_cnt.
REQ-021 DONE SHALL last exactly one cycle with done=1 and SHALL then return to IDLE.
REQ-022 stop=1 in RUN SHALL force IDLE on the next edge and drop out_valid, without asserting done.
REQ-023 stop SHALL take priority over a simultaneous transfer; that transfer is consumed but gray_out does not advance.
REQ-024 start outside IDLE, or start and stop together in IDLE, SHALL be ignored.
REQ-025 In IDLE, gray_out SHALL hold its last value.
REQ-026 Latency: first out_valid one cycle after start; one code per cycle when out_ready is held high.

Reset
REQ-027 reset=0 SHALL immediately force IDLE, gray_out=0, out_valid=0, busy=0, done=0 and wrap_cnt=0, including mid-sequence.
REQ-028 The first sequence after reset deassertion SHALL require a new start.

Configuration
REQ-029 With GRAY_SEQ_BIN_EN defined, the block SHALL add output bin_out[N-1:0], the combinational binary equivalent of gray_out (reset value 0).
REQ-030 Without GRAY_SEQ_BIN_EN, port bin_out and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-031 The shared package gray_pkg SHALL hold the state encoding (IDLE/RUN/DONE), the default width constant and the gray-to-binary and binary-to-Gray conversion functions.
REQ-032 The block SHALL contain one sub-module, gray_cnt_core: an N-bit Gray register with step enable and synchronous clear, driven by the controller.

Verification (N=4)
REQ-033 One-shot test: start with mode=0, term_gray=0110 and out_ready=1 -> gray_out shows 0000, 0001, 0011, 0010, 0110 on consecutive cycles, then done pulses once, then busy=0.
REQ-034 Continuous test: mode=1, term_gray=1000 and 40 transfers -> 16-code cycle repeats and wrap_cnt=2 after the 32nd transfer; every step changes exactly one bit.
REQ-035 Backpressure test: out_ready=0 for 5 cycles at gray_out=0011 -> gray_out stays 0011 and out_valid stays 1; the next code after release is 0010.
REQ-036 Stop test: stop together with a transfer at gray_out=0010 -> next cycle is IDLE, gray_out=0010 and done never asserts.
REQ-037 Reset test: reset low mid-RUN at gray_out=0111 -> all outputs zero immediately; a start while busy is ignored; in the GRAY_SEQ_BIN_EN build, bin_out tracks gray_out throughout.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared definitions for the Gray sequence controller: FSM state encoding,
// default width and Gray/binary conversion helpers (sized to GRAY_W_MAX).
package gray_pkg;

  localparam int GRAY_W_DEFAULT = 4;
  localparam int GRAY_W_MAX     = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Callers zero-extend narrower codes; leading zeros do not disturb the result.
  function automatic logic [GRAY_W_MAX-1:0] gray_to_bin(input logic [GRAY_W_MAX-1:0] g);
    logic [GRAY_W_MAX-1:0] b;
    b = g;
    for (int i = GRAY_W_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [GRAY_W_MAX-1:0] bin_to_gray(input logic [GRAY_W_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_cnt_core.sv
// N-bit Gray code register: synchronous clear to zero, or one reflected-binary
// step when enabled. Stepping from the 2^N-1 code wraps naturally to zero.
module gray_cnt_core
  import gray_pkg::*;
#(
  parameter int N = GRAY_W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         step,
  input  logic         clear,
  output logic [N-1:0] gray
);

  logic [N-1:0] bin_cur;
  logic [N-1:0] bin_nxt;
  logic [N-1:0] gray_nxt;

  // The increment is done at width N so the count wraps modulo 2^N.
  assign bin_cur  = N'(gray_to_bin(GRAY_W_MAX'(gray)));
  assign bin_nxt  = bin_cur + N'(1);
  assign gray_nxt = N'(bin_to_gray(GRAY_W_MAX'(bin_nxt)));

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gray <= '0;
    end else if (clear) begin
      gray <= '0;
    end else if (step) begin
      gray <= gray_nxt;
    end
  end

endmodule

// File: rtl/gray_seq_ctrl.sv
// Gray sequence controller with valid/ready output, one-shot and continuous
// modes. Defining GRAY_SEQ_BIN_EN adds the bin_out port (binary of gray_out).
module gray_seq_ctrl
  import gray_pkg::*;
#(
  parameter int N = GRAY_W_DEFAULT  // 2 .. GRAY_W_MAX
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic         mode,
  input  logic [N-1:0] term_gray,
  input  logic         out_ready,
  output logic [N-1:0] gray_out,
  output logic         out_valid,
  output logic         busy,
  output logic         done,
  output logic [7:0]   wrap_cnt
`ifdef GRAY_SEQ_BIN_EN
  ,
  output logic [N-1:0] bin_out
`endif
);

  state_t       state;
  state_t       state_nxt;
  logic         mode_q;
  logic [N-1:0] term_q;
  logic         launch;
  logic         step;
  logic         clear;
  logic         wrap;
  logic         at_term;

  assign at_term = (gray_out == term_q);

  gray_cnt_core #(.N(N)) u_core (
    .clk   (clk),
    .reset (reset),
    .step  (step),
    .clear (clear),
    .gray  (gray_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start && !stop) state_nxt = ST_RUN;
      ST_RUN: begin
        if (stop) begin
          state_nxt = ST_IDLE;
        end else if (out_ready && at_term && !mode_q) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stop wins over a simultaneous transfer: the beat is consumed, no step.
  always_comb begin
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    launch    = 1'b0;
    step      = 1'b0;
    clear     = 1'b0;
    wrap      = 1'b0;
    case (state)
      ST_IDLE: begin
        launch = start && !stop;
        clear  = launch;
      end
      ST_RUN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (!stop && out_ready) begin
          if (!at_term) begin
            step = 1'b1;
          end else if (mode_q) begin
            clear = 1'b1;
            wrap  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q <= 1'b0;
      term_q <= '0;
    end else if (launch) begin
      mode_q <= mode;
      term_q <= term_gray;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrap_cnt <= '0;
    end else if (launch) begin
      wrap_cnt <= '0;
    end else if (wrap && (wrap_cnt != 8'hFF)) begin
      wrap_cnt <= wrap_cnt + 8'd1;
    end
  end

`ifdef GRAY_SEQ_BIN_EN
  assign bin_out = N'(gray_to_bin(GRAY_W_MAX'(gray_out)));
`endif

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Self-checking bench for gray_seq_ctrl (N=4): directed scenarios plus random
// traffic, compared each cycle against an index-based sequence model.
module tb_gray_seq_ctrl;

  localparam int N = 4;
  localparam int CODES = 1 << N;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         stop;
  logic         mode;
  logic [N-1:0] term_gray;
  logic         out_ready;
  logic [N-1:0] gray_out;
  logic         out_valid;
  logic         busy;
  logic         done;
  logic [7:0]   wrap_cnt;
`ifdef GRAY_SEQ_BIN_EN
  logic [N-1:0] bin_out;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: position in the binary count, translated to Gray on compare.
  bit m_active, m_done, m_mode;
  int m_idx, m_term_idx, m_wraps;

  gray_seq_ctrl #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .term_gray (term_gray),
    .out_ready (out_ready),
    .gray_out  (gray_out),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done),
    .wrap_cnt  (wrap_cnt)
`ifdef GRAY_SEQ_BIN_EN
    ,
    .bin_out   (bin_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int to_gray(input int k);
    return k ^ (k >> 1);
  endfunction

  function automatic int gray_index(input logic [N-1:0] g);
    for (int k = 0; k < CODES; k++) begin
      if (to_gray(k) == int'(g)) return k;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_active = 0; m_done = 0; m_mode = 0;
    m_idx = 0; m_term_idx = 0; m_wraps = 0;
  endtask

  task automatic model_update();
    if (m_done) begin
      m_done = 0;
    end else if (!m_active) begin
      if (start && !stop) begin
        m_active   = 1;
        m_idx      = 0;
        m_mode     = mode;
        m_term_idx = gray_index(term_gray);
        m_wraps    = 0;
      end
    end else if (stop) begin
      m_active = 0;
    end else if (out_ready) begin
      if (m_idx == m_term_idx) begin
        if (m_mode) begin
          m_idx = 0;
          if (m_wraps < 255) m_wraps++;
        end else begin
          m_active = 0;
          m_done   = 1;
        end
      end else begin
        m_idx = (m_idx + 1) % CODES;
      end
    end
  endtask

  task automatic compare_all();
    check("gray_out", 32'(gray_out), 32'(to_gray(m_idx)));
    check("out_valid", 32'(out_valid), 32'(m_active));
    check("busy", 32'(busy), 32'(m_active | m_done));
    check("done", 32'(done), 32'(m_done));
    check("wrap_cnt", 32'(wrap_cnt), 32'(m_wraps));
`ifdef GRAY_SEQ_BIN_EN
    check("bin_out", 32'(bin_out), 32'(m_idx));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    start = 0; stop = 0; mode = 0; term_gray = '0; out_ready = 0;
  endtask

  task automatic launch(input logic m, input logic [N-1:0] t, input logic rdy);
    start = 1; stop = 0; mode = m; term_gray = t; out_ready = rdy;
    tick();
    start = 0;
  endtask

  logic [N-1:0] oneshot_seq [5];
  logic [N-1:0] prev_gray;

  initial begin
    oneshot_seq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110};
    idle_inputs();
    model_reset();
    reset = 0;
    #2;
    compare_all();
    check("reset_gray", 32'(gray_out), 32'h0);
    @(negedge clk);
    reset = 1;
    repeat (2) tick();

    // Start together with stop in IDLE is ignored.
    start = 1; stop = 1;
    tick();
    check("start_stop_idle_busy", 32'(busy), 32'h0);
    idle_inputs();

    // One-shot to 0110 with the consumer always ready.
    launch(1'b0, 4'b0110, 1'b1);
    check("oneshot_code0", 32'(gray_out), 32'(oneshot_seq[0]));
    for (int k = 1; k < 5; k++) begin
      tick();
      check("oneshot_code", 32'(gray_out), 32'(oneshot_seq[k]));
    end
    tick();
    check("oneshot_done", 32'(done), 32'h1);
    check("oneshot_done_valid", 32'(out_valid), 32'h0);
    tick();
    check("oneshot_idle_busy", 32'(busy), 32'h0);
    check("oneshot_idle_done", 32'(done), 32'h0);
    check("oneshot_idle_hold", 32'(gray_out), 32'b0110);

    // Continuous to 1000: full 16-code cycle, two restarts after 32 transfers.
    launch(1'b1, 4'b1000, 1'b1);
    for (int k = 1; k <= 40; k++) begin
      prev_gray = gray_out;
      tick();
      check("cont_one_bit", 32'($countones(prev_gray ^ gray_out)), 32'd1);
      if (k == 32) check("cont_wrap_after_32", 32'(wrap_cnt), 32'd2);
      if (k == 15) check("cont_code15", 32'(gray_out), 32'b1000);
      if (k == 16) check("cont_reload", 32'(gray_out), 32'b0000);
    end
    stop = 1; out_ready = 0;
    tick();
    idle_inputs();

    // Backpressure at 0011, then stop together with a transfer at 0010.
    launch(1'b0, 4'b1000, 1'b1);
    repeat (2) tick();
    check("bp_at_0011", 32'(gray_out), 32'b0011);
    out_ready = 0;
    repeat (5) begin
      tick();
      check("bp_hold", 32'(gray_out), 32'b0011);
      check("bp_valid", 32'(out_valid), 32'h1);
    end
    out_ready = 1;
    tick();
    check("bp_release", 32'(gray_out), 32'b0010);
    stop = 1;
    tick();
    check("stop_idle", 32'(busy), 32'h0);
    check("stop_hold", 32'(gray_out), 32'b0010);
    idle_inputs();
    repeat (3) begin
      tick();
      check("stop_no_done", 32'(done), 32'h0);
    end

    // Asynchronous reset mid-run at 0111.
    launch(1'b1, 4'b1000, 1'b1);
    repeat (5) tick();
    check("rst_pre_0111", 32'(gray_out), 32'b0111);
    #2;
    reset = 0;
    #1;
    model_reset();
    check("rst_now_gray", 32'(gray_out), 32'h0);
    check("rst_now_valid", 32'(out_valid), 32'h0);
    check("rst_now_busy", 32'(busy), 32'h0);
    compare_all();
    idle_inputs();
    @(negedge clk);
    reset = 1;
    repeat (3) tick();
    check("rst_needs_start", 32'(busy), 32'h0);

    // A start while busy must not relatch mode/terminal.
    launch(1'b1, 4'b0011, 1'b0);
    launch(1'b0, 4'b0000, 1'b1);
    repeat (6) tick();
    check("busy_start_ignored", 32'(busy), 32'h1);
    stop = 1;
    tick();
    idle_inputs();

    // Restart counter saturates at 255.
    launch(1'b1, 4'b0000, 1'b1);
    repeat (260) tick();
    check("wrap_saturate", 32'(wrap_cnt), 32'd255);
    stop = 1;
    tick();
    idle_inputs();

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      start     = ($urandom_range(0, 7) == 0);
      stop      = ($urandom_range(0, 15) == 0);
      mode      = 1'($urandom_range(0, 1));
      term_gray = N'($urandom_range(0, CODES - 1));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
